// File: rtl/temp_countdown_ctrl_pkg.sv
// temp_countdown_ctrl_pkg: state encoding and default width shared by the countdown, display and control logic
package temp_countdown_ctrl_pkg;
  localparam int DEF_WIDTH = 6;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/temp_countdown_ctrl_tick_edge_det.sv
// tick_edge_det: registered rising-edge detector; a level held high yields a single pulse
module tick_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic in_q;
  always_ff @(posedge clk) in_q <= reset ? 1'b0 : in;
  assign pulse = in & ~in_q;
endmodule

// File: rtl/temp_countdown_ctrl.sv
// temp_countdown_ctrl: loads a tick count and counts it down on tick edges, with pause, cancel and expiry reporting
module temp_countdown_ctrl
  import temp_countdown_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             pause,
  input  logic             cancel,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             expired,
  output logic [WIDTH-1:0] remaining,
  output logic [1:0]       state
);
  state_t st_q, st_n;
  logic [WIDTH-1:0] rem_n;
  logic tick_ev, exp_n;
  tick_edge_det u_tick_edge (.clk(clk), .reset(reset), .in(tick), .pulse(tick_ev));
  always_comb begin
    st_n  = st_q;
    rem_n = remaining;
    exp_n = 1'b0;
    if (cancel) begin
      st_n  = ST_IDLE;
      rem_n = '0;
    end else if (start) begin
      rem_n = load_val;
      st_n  = (load_val != '0) ? ST_RUN : ST_DONE;
      exp_n = (load_val == '0);
    end else begin
      case (st_q)
        ST_RUN:
          if (pause) st_n = ST_PAUSE;
          else if (tick_ev) begin
            // a count of 1 (or 0) finishes instead of wrapping
            rem_n = (remaining > WIDTH'(1)) ? remaining - WIDTH'(1) : '0;
            st_n  = (remaining > WIDTH'(1)) ? ST_RUN : ST_DONE;
            exp_n = (remaining <= WIDTH'(1));
          end
        ST_PAUSE: st_n = pause ? ST_PAUSE : ST_RUN;
        ST_DONE:  st_n = ack ? ST_IDLE : ST_DONE;
        default:  st_n = ST_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= ST_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      expired   <= 1'b0;
    end else begin
      st_q      <= st_n;
      remaining <= rem_n;
      busy      <= (st_n == ST_RUN) || (st_n == ST_PAUSE);
      done      <= (st_n == ST_DONE);
      expired   <= exp_n;
    end
  end
  assign state = st_q;
endmodule

// File: tb/tb_temp_countdown_ctrl.sv
// tb_temp_countdown_ctrl: table-driven vectors and tick-paced sequences checked through an expectation queue
module tb_temp_countdown_ctrl;
  import temp_countdown_ctrl_pkg::*;
  logic clk = 0, reset = 1, tick = 0, start = 0, pause = 0, cancel = 0, ack = 0;
  logic [5:0] load_val = '0, remaining;
  logic busy, done, expired;
  logic [1:0] state;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [1:0] st;
    logic [5:0] rem;
    logic busy, done, exp;
  } exp_t;
  typedef struct packed {
    logic t, s;
    logic [5:0] lv;
    logic p, c, a;
    exp_t e;
  } vec_t;
  exp_t sb[$];
  vec_t vecs[33];
  temp_countdown_ctrl #(.WIDTH(6)) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .load_val(load_val),
    .pause(pause), .cancel(cancel), .ack(ack), .busy(busy), .done(done),
    .expired(expired), .remaining(remaining), .state(state)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  function automatic exp_t mk(logic [1:0] st, logic [5:0] r, logic b, logic d, logic x);
    return {st, r, b, d, x};
  endfunction
  function automatic vec_t v(logic t, logic s, logic [5:0] lv, logic p, logic c, logic a, exp_t e);
    return {t, s, lv, p, c, a, e};
  endfunction
  task automatic chk(input string name);
    exp_t e, got;
    got = {state, remaining, busy, done, expired};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: no expectation queued, got st=%0d rem=%0d", name, state, remaining);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d rem=%0d busy=%b done=%b exp=%b, required st=%0d rem=%0d busy=%b done=%b exp=%b",
                 name, got.st, got.rem, got.busy, got.done, got.exp, e.st, e.rem, e.busy, e.done, e.exp);
      end
    end
  endtask
  task automatic step(input logic t, input logic s, input logic [5:0] lv, input logic p,
                      input logic c, input logic a, input exp_t e, input string name);
    tick = t; start = s; load_val = lv; pause = p; cancel = c; ack = a;
    sb.push_back(e);
    @(posedge clk); #1;
    chk(name);
  endtask
  initial begin
    vecs[0]  = v(1, 0, 0, 1, 0, 1, mk(ST_IDLE, 0, 0, 0, 0));
    vecs[1]  = v(0, 1, 4, 0, 0, 0, mk(ST_RUN, 4, 1, 0, 0));
    vecs[2]  = v(1, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[3]  = v(1, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[4]  = v(0, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[5]  = v(1, 0, 0, 1, 0, 0, mk(ST_PAUSE, 3, 1, 0, 0));
    vecs[6]  = v(0, 0, 0, 1, 0, 0, mk(ST_PAUSE, 3, 1, 0, 0));
    vecs[7]  = v(1, 0, 0, 1, 0, 0, mk(ST_PAUSE, 3, 1, 0, 0));
    vecs[8]  = v(0, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[9]  = v(1, 0, 0, 0, 0, 0, mk(ST_RUN, 2, 1, 0, 0));
    vecs[10] = v(0, 0, 0, 0, 0, 0, mk(ST_RUN, 2, 1, 0, 0));
    vecs[11] = v(1, 0, 0, 0, 1, 0, mk(ST_IDLE, 0, 0, 0, 0));
    vecs[12] = v(0, 1, 0, 0, 0, 0, mk(ST_DONE, 0, 0, 1, 1));
    vecs[13] = v(0, 0, 0, 0, 0, 0, mk(ST_DONE, 0, 0, 1, 0));
    vecs[14] = v(1, 0, 0, 0, 0, 0, mk(ST_DONE, 0, 0, 1, 0));
    vecs[15] = v(0, 1, 7, 0, 0, 1, mk(ST_RUN, 7, 1, 0, 0));
    vecs[16] = v(1, 1, 1, 0, 0, 0, mk(ST_RUN, 1, 1, 0, 0));
    vecs[17] = v(0, 0, 0, 0, 0, 0, mk(ST_RUN, 1, 1, 0, 0));
    vecs[18] = v(1, 0, 0, 0, 0, 0, mk(ST_DONE, 0, 0, 1, 1));
    vecs[19] = v(0, 0, 0, 0, 0, 0, mk(ST_DONE, 0, 0, 1, 0));
    vecs[20] = v(0, 0, 0, 0, 0, 1, mk(ST_IDLE, 0, 0, 0, 0));
    vecs[21] = v(0, 1, 2, 1, 0, 0, mk(ST_RUN, 2, 1, 0, 0));
    vecs[22] = v(0, 0, 0, 1, 0, 0, mk(ST_PAUSE, 2, 1, 0, 0));
    vecs[23] = v(0, 1, 5, 1, 0, 0, mk(ST_RUN, 5, 1, 0, 0));
    vecs[24] = v(0, 0, 0, 0, 0, 1, mk(ST_RUN, 5, 1, 0, 0));
    vecs[25] = v(0, 1, 9, 0, 1, 0, mk(ST_IDLE, 0, 0, 0, 0));
    vecs[26] = v(0, 1, 3, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[27] = v(0, 0, 0, 1, 0, 0, mk(ST_PAUSE, 3, 1, 0, 0));
    vecs[28] = v(1, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[29] = v(1, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[30] = v(0, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0));
    vecs[31] = v(1, 0, 0, 0, 0, 0, mk(ST_RUN, 2, 1, 0, 0));
    vecs[32] = v(0, 0, 0, 0, 1, 0, mk(ST_IDLE, 0, 0, 0, 0));
    reset = 1;
    step(0, 0, 0, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0), "reset");
    reset = 0;
    for (int i = 0; i < 33; i++)
      step(vecs[i].t, vecs[i].s, vecs[i].lv, vecs[i].p, vecs[i].c, vecs[i].a, vecs[i].e, $sformatf("vec%0d", i));
    // load 3, ticks every 15 clocks: expiry one clock after the third tick edge
    step(0, 1, 3, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0), "a_start");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, 0, mk(ST_RUN, 6'(3 - k), 1, 0, 0), "a_wait");
      step(1, 0, 0, 0, 0, 0, (k < 2) ? mk(ST_RUN, 6'(2 - k), 1, 0, 0) : mk(ST_DONE, 0, 0, 1, 1), "a_tick");
    end
    step(0, 0, 0, 0, 0, 0, mk(ST_DONE, 0, 0, 1, 0), "a_after");
    step(0, 0, 0, 0, 0, 1, mk(ST_IDLE, 0, 0, 0, 0), "a_ack");
    // load 5, pause across two ticks, then finish
    step(0, 1, 5, 0, 0, 0, mk(ST_RUN, 5, 1, 0, 0), "b_start");
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, 0, mk(ST_RUN, 6'(5 - k), 1, 0, 0), "b_wait");
      step(1, 0, 0, 0, 0, 0, mk(ST_RUN, 6'(4 - k), 1, 0, 0), "b_tick");
    end
    for (int i = 0; i < 40; i++) step(i % 15 == 14, 0, 0, 1, 0, 0, mk(ST_PAUSE, 3, 1, 0, 0), "b_pause");
    step(0, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0), "b_resume");
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 14; i++) step(0, 0, 0, 0, 0, 0, mk(ST_RUN, 6'(3 - k), 1, 0, 0), "b_wait2");
      step(1, 0, 0, 0, 0, 0, (k < 2) ? mk(ST_RUN, 6'(2 - k), 1, 0, 0) : mk(ST_DONE, 0, 0, 1, 1), "b_tick2");
    end
    step(0, 0, 0, 0, 0, 1, mk(ST_IDLE, 0, 0, 0, 0), "b_ack");
    // tick held high for 20 cycles counts once
    step(0, 1, 4, 0, 0, 0, mk(ST_RUN, 4, 1, 0, 0), "c_start");
    step(0, 0, 0, 0, 0, 0, mk(ST_RUN, 4, 1, 0, 0), "c_low");
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0), "c_held");
    step(0, 0, 0, 0, 0, 0, mk(ST_RUN, 3, 1, 0, 0), "c_release");
    step(0, 0, 0, 0, 1, 0, mk(ST_IDLE, 0, 0, 0, 0), "c_cancel");
    // reset mid-count aborts without an expiry pulse
    step(0, 1, 5, 0, 0, 0, mk(ST_RUN, 5, 1, 0, 0), "d_start");
    step(1, 0, 0, 0, 0, 0, mk(ST_RUN, 4, 1, 0, 0), "d_tick");
    step(0, 0, 0, 0, 0, 0, mk(ST_RUN, 4, 1, 0, 0), "d_low");
    reset = 1;
    step(1, 0, 0, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0), "d_reset");
    reset = 0;
    step(0, 0, 0, 0, 0, 0, mk(ST_IDLE, 0, 0, 0, 0), "d_after");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
